// File: rtl/pixel_scheduler_pkg.sv
// Shared types and default frame geometry for the pixel scheduler and its arbiter.
package pixel_scheduler_pkg;

  localparam int FRAC   = 16;
  localparam int WIDTH  = 640;
  localparam int HEIGHT = 480;

  typedef logic signed [31:0] coord_t;
  typedef logic [9:0]         pix_x_t;
  typedef logic [8:0]         pix_y_t;
  typedef logic [9:0]         depth_t;

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN} sched_state_t;

endpackage

// File: rtl/pixel_scheduler_rr_arbiter.sv
// Round-robin arbiter: one-hot grant, search starts at ptr, ptr moves past the grant on accept.
module rr_arbiter
  import pixel_scheduler_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         sysclk,
  input  logic         reset,
  input  logic [N-1:0] req,
  input  logic         accept,
  output logic [N-1:0] grant
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr;
  logic          found;

  // Two passes: indices at/after ptr first, then the wrapped ones.
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!found && req[k] && k >= int'(ptr)) begin
        grant[k] = 1'b1;
        found    = 1'b1;
      end
    end
    for (int k = 0; k < N; k++) begin
      if (!found && req[k] && k < int'(ptr)) begin
        grant[k] = 1'b1;
        found    = 1'b1;
      end
    end
  end

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      ptr <= '0;
    end else if (accept) begin
      for (int k = 0; k < N; k++) begin
        if (grant[k]) ptr <= (k == N - 1) ? '0 : PW'(k + 1);
      end
    end
  end

endmodule

// File: rtl/pixel_scheduler.sv
// Raster-scans a frame, dispatches each pixel's c to a free engine and streams tagged results.
module pixel_scheduler
  import pixel_scheduler_pkg::*;
#(
  parameter int N_ENG  = 4,
  parameter int WIDTH  = pixel_scheduler_pkg::WIDTH,
  parameter int HEIGHT = pixel_scheduler_pkg::HEIGHT
) (
  input  logic                sysclk,
  input  logic                reset,
  input  logic                frame_start,
  input  logic [31:0]         re_origin,
  input  logic [31:0]         im_origin,
  input  logic [31:0]         step,
  output logic [N_ENG-1:0]    eng_start,
  output logic [N_ENG*32-1:0] eng_re_c,
  output logic [N_ENG*32-1:0] eng_im_c,
  input  logic [N_ENG-1:0]    eng_done,
  input  logic [N_ENG*10-1:0] eng_depth,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [9:0]          out_x,
  output logic [8:0]          out_y,
  output logic [9:0]          out_depth,
  output logic                busy,
  output logic                frame_done
);

  sched_state_t state, state_nxt;
  coord_t cur_re, cur_im, re0, step_q;
  coord_t b_re, b_im, b_re0, b_step;
  pix_x_t x, b_x, sel_x;
  pix_y_t y, b_y, sel_y;
  depth_t sel_d;
  logic   idle_start, dispatch, last_px, can_load, collect, drain_done;

  logic [N_ENG-1:0]       busy_q, start_q, disp_oh, done_ok, grant;
  logic [N_ENG-1:0][1:0]  hold_cnt;
  logic [N_ENG-1:0][31:0] re_c_q, im_c_q;
  logic [N_ENG-1:0][9:0]  tag_x, depth_in;
  logic [N_ENG-1:0][8:0]  tag_y;

  assign depth_in = eng_depth;

  // A frame_start in IDLE dispatches pixel (0,0) straight from the view inputs.
  assign idle_start = (state == IDLE) && frame_start;
  assign b_x    = idle_start ? '0 : x;
  assign b_y    = idle_start ? '0 : y;
  assign b_re   = idle_start ? coord_t'(re_origin) : cur_re;
  assign b_im   = idle_start ? coord_t'(im_origin) : cur_im;
  assign b_re0  = idle_start ? coord_t'(re_origin) : re0;
  assign b_step = idle_start ? coord_t'(step)      : step_q;

  assign disp_oh    = ~busy_q & (busy_q + N_ENG'(1));
  assign dispatch   = (idle_start || state == SCAN) && !(&busy_q);
  assign last_px    = (b_x == pix_x_t'(WIDTH - 1)) && (b_y == pix_y_t'(HEIGHT - 1));
  assign can_load   = !out_valid || out_ready;
  assign collect    = can_load && (|done_ok);
  assign drain_done = (state == DRAIN) && (busy_q == '0) && !out_valid;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (frame_start) state_nxt = (dispatch && last_px) ? DRAIN : SCAN;
      SCAN:    if (dispatch && last_px) state_nxt = DRAIN;
      DRAIN:   if (drain_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The first two cycles after a start still see the previous pixel's done level.
  always_comb begin
    done_ok = '0;
    for (int k = 0; k < N_ENG; k++)
      done_ok[k] = busy_q[k] && eng_done[k] && (hold_cnt[k] == 2'd0);
  end

  always_comb begin
    sel_x = '0;
    sel_y = '0;
    sel_d = '0;
    for (int k = 0; k < N_ENG; k++) begin
      if (grant[k]) begin
        sel_x = sel_x | tag_x[k];
        sel_y = sel_y | tag_y[k];
        sel_d = sel_d | depth_in[k];
      end
    end
  end

  rr_arbiter #(.N(N_ENG)) u_arb (
    .sysclk (sysclk),
    .reset  (reset),
    .req    (done_ok),
    .accept (collect),
    .grant  (grant)
  );

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cur_re     <= '0;
      cur_im     <= '0;
      re0        <= '0;
      step_q     <= '0;
      x          <= '0;
      y          <= '0;
      busy_q     <= '0;
      start_q    <= '0;
      hold_cnt   <= '0;
      re_c_q     <= '0;
      im_c_q     <= '0;
      tag_x      <= '0;
      tag_y      <= '0;
      out_valid  <= 1'b0;
      out_x      <= '0;
      out_y      <= '0;
      out_depth  <= '0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      frame_done <= drain_done;
      if (idle_start) begin
        re0    <= coord_t'(re_origin);
        step_q <= coord_t'(step);
      end
      if (dispatch) begin
        if (b_x == pix_x_t'(WIDTH - 1)) begin
          x      <= '0;
          y      <= b_y + pix_y_t'(1);
          cur_re <= b_re0;
          cur_im <= b_im + b_step;
        end else begin
          x      <= b_x + pix_x_t'(1);
          y      <= b_y;
          cur_re <= b_re + b_step;
          cur_im <= b_im;
        end
      end else if (idle_start) begin
        x      <= '0;
        y      <= '0;
        cur_re <= coord_t'(re_origin);
        cur_im <= coord_t'(im_origin);
      end
      for (int k = 0; k < N_ENG; k++) begin
        start_q[k] <= dispatch && disp_oh[k];
        if (dispatch && disp_oh[k]) begin
          re_c_q[k]   <= b_re;
          im_c_q[k]   <= b_im;
          tag_x[k]    <= b_x;
          tag_y[k]    <= b_y;
          busy_q[k]   <= 1'b1;
          hold_cnt[k] <= 2'd2;
        end else begin
          if (hold_cnt[k] != 2'd0) hold_cnt[k] <= hold_cnt[k] - 2'd1;
          if (collect && grant[k]) busy_q[k] <= 1'b0;
        end
      end
      if (collect) begin
        out_valid <= 1'b1;
        out_x     <= sel_x;
        out_y     <= sel_y;
        out_depth <= sel_d;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign eng_start = start_q;
  assign eng_re_c  = re_c_q;
  assign eng_im_c  = im_c_q;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_pixel_scheduler.sv
// Random-latency stub engines and random backpressure checked against a raster/scoreboard model.
module tb_pixel_scheduler;

  localparam int N   = 4;
  localparam int W   = 8;
  localparam int H   = 4;
  localparam int TOT = W * H;

  logic            sysclk = 1'b0;
  logic            reset;
  logic            frame_start;
  logic [31:0]     re_origin, im_origin, step;
  logic [N-1:0]    eng_start;
  logic [N*32-1:0] eng_re_c, eng_im_c;
  logic [N-1:0]    eng_done;
  logic [N*10-1:0] eng_depth;
  logic            out_valid, out_ready;
  logic [9:0]      out_x, out_depth;
  logic [8:0]      out_y;
  logic            busy, frame_done;

  always #5 sysclk = ~sysclk;

  pixel_scheduler #(.N_ENG(N), .WIDTH(W), .HEIGHT(H)) dut (
    .sysclk(sysclk), .reset(reset), .frame_start(frame_start),
    .re_origin(re_origin), .im_origin(im_origin), .step(step),
    .eng_start(eng_start), .eng_re_c(eng_re_c), .eng_im_c(eng_im_c),
    .eng_done(eng_done), .eng_depth(eng_depth),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_x(out_x), .out_y(out_y), .out_depth(out_depth),
    .busy(busy), .frame_done(frame_done)
  );

  int          n_chk, n_fail;
  int          disp_n, n_res, nfd, stall;
  logic [31:0] m_re0, m_im0, m_step;
  bit          seen [TOT];
  int          pix [N];
  bit          inuse [N];
  int          rem [N];
  bit          clr [N];
  logic [31:0] st_re [N], st_im [N];
  bit          prev_valid, prev_acc;
  logic [9:0]  hx, hd;
  logic [8:0]  hy;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Stub engine result: any fixed function of the engine's c inputs.
  function automatic logic [9:0] hsh(input logic [31:0] r, input logic [31:0] i);
    return r[23:14] ^ {i[18:14], i[23:19]} ^ r[9:0] ^ i[31:22];
  endfunction

  task automatic clear_model();
    for (int k = 0; k < N; k++) begin
      inuse[k] = 0; rem[k] = 0; clr[k] = 0;
    end
    eng_done   = '0;
    prev_valid = 0;
    prev_acc   = 0;
    stall      = 0;
  endtask

  task automatic tick();
    int          p, nst;
    bit          found, acc;
    logic [31:0] er, ei, ar, ai;
    @(negedge sysclk);
    frame_start = 1'b0;
    if (stall > 0) begin
      out_ready = 1'b0;
      stall--;
    end else begin
      out_ready = ($urandom_range(3) != 0);
    end
    if (prev_valid && !prev_acc) begin
      check("hold_valid", out_valid, 1);
      check("hold_data", {out_x, out_y, out_depth}, {hx, hy, hd});
    end
    // A freshly loaded result frees the engine that computed that pixel.
    if (out_valid && (!prev_valid || prev_acc)) begin
      p = int'(out_y) * W + int'(out_x);
      found = 0;
      for (int k = 0; k < N; k++) begin
        if (!found && inuse[k] && pix[k] == p) begin
          found = 1;
          check("collect_done", eng_done[k], 1);
          inuse[k] = 0;
        end
      end
      check("tag_match", found, 1);
    end
    acc = out_valid && out_ready;
    if (acc) begin
      check("range", (out_x < W) && (out_y < H), 1);
      if (out_x < W && out_y < H) begin
        p = int'(out_y) * W + int'(out_x);
        check("dup", seen[p], 0);
        seen[p] = 1;
        er = m_re0 + m_step * 32'(out_x);
        ei = m_im0 + m_step * 32'(out_y);
        check("depth", out_depth, hsh(er, ei));
      end
      n_res++;
    end
    prev_valid = out_valid;
    prev_acc   = acc;
    hx = out_x; hy = out_y; hd = out_depth;
    if (frame_done) begin
      nfd++;
      check("fd_after_all", n_res, TOT);
    end
    nst = $countones(eng_start);
    if (nst > 0) check("one_start", nst <= 1, 1);
    for (int k = 0; k < N; k++) begin
      ar = eng_re_c[k*32 +: 32];
      ai = eng_im_c[k*32 +: 32];
      if (eng_start[k]) begin
        check("start_busy", inuse[k], 0);
        p  = disp_n;
        er = m_re0 + m_step * 32'(p % W);
        ei = m_im0 + m_step * 32'(p / W);
        check("re_c", ar, er);
        check("im_c", ai, ei);
        if (m_step == 32'hFFFF0000 && p == 2) check("neg_x2", ar, 32'h0);
        pix[k]   = p;
        inuse[k] = 1;
        disp_n++;
        st_re[k] = ar;
        st_im[k] = ai;
        rem[k]   = $urandom_range(8, 1);
        clr[k]   = 1;
      end else begin
        if (inuse[k] && rem[k] > 0) check("c_hold", {ar[15:0], ai[15:0]}, {st_re[k][15:0], st_im[k][15:0]});
        if (clr[k]) begin
          eng_done[k] = 1'b0;
          clr[k] = 0;
        end
        if (rem[k] > 0) begin
          rem[k]--;
          if (rem[k] == 0) begin
            eng_done[k] = 1'b1;
            eng_depth[k*10 +: 10] = hsh(st_re[k], st_im[k]);
          end
        end
      end
    end
  endtask

  // mode 0: plain frame, 1: stall + ignored frame_start, 2: reset during drain
  task automatic run_frame(input logic [31:0] r0, input logic [31:0] i0, input logic [31:0] st,
                           input int mode);
    int cyc;
    bit fin;
    m_re0 = r0; m_im0 = i0; m_step = st;
    disp_n = 0; n_res = 0; nfd = 0;
    for (int p = 0; p < TOT; p++) seen[p] = 0;
    re_origin = r0; im_origin = i0; step = st;
    frame_start = 1'b1;
    tick();
    check("lat1", eng_start[0], 1);
    check("busy_start", busy, 1);
    cyc = 0;
    fin = 0;
    while (!fin && cyc < 3000) begin
      tick();
      cyc++;
      if (mode == 1 && cyc == 5) begin
        check("busy_scan", busy, 1);
        frame_start = 1'b1;
        re_origin = ~r0;
        step = st + 32'h1;
      end
      if (mode == 1 && cyc == 12) stall = 50;
      if (mode == 2 && disp_n == TOT) begin
        check("drain_busy", busy, 1);
        reset = 1'b1;
        #1;
        check("arst_busy", busy, 0);
        check("arst_valid", out_valid, 0);
        check("arst_start", eng_start, 0);
        check("arst_c", |{eng_re_c, eng_im_c}, 0);
        check("arst_out", {out_x, out_y, out_depth}, 0);
        check("arst_fd", frame_done, 0);
        clear_model();
        @(negedge sysclk);
        reset = 1'b0;
        return;
      end
      if (nfd > 0) fin = 1;
    end
    if (fin) repeat (3) tick();
    check("all_results", n_res, TOT);
    check("fd_once", nfd, 1);
    check("idle_after", busy, 0);
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    reset = 1'b1;
    frame_start = 1'b0;
    re_origin = '0; im_origin = '0; step = '0;
    out_ready = 1'b0;
    eng_depth = '0;
    clear_model();
    #12;
    check("rst_busy", busy, 0);
    check("rst_valid", out_valid, 0);
    check("rst_start", eng_start, 0);
    check("rst_c", |{eng_re_c, eng_im_c}, 0);
    check("rst_out", {out_x, out_y, out_depth}, 0);
    check("rst_fd", frame_done, 0);
    @(negedge sysclk);
    reset = 1'b0;
    run_frame(32'h0, 32'h0, 32'h4000, 0);
    run_frame(32'h00020000, 32'h0, 32'hFFFF0000, 0);
    run_frame($urandom, $urandom, $urandom, 1);
    run_frame($urandom, $urandom, $urandom, 2);
    run_frame(32'h7FFFF000, 32'hFFFF8000, 32'h00001000, 0);
    repeat (3) run_frame($urandom, $urandom, $urandom, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
